// File: rtl/mdio_pkg.sv
// mdio_pkg
// Shared definitions for the PHY-side MDIO responder: Clause-22 frame codes,
// bit positions inside the 32-bit frame, the responder state type and a
// helper that identifies the read-only PHY identifier registers.
package mdio_pkg;

  // Frame field codes
  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // First bit index of each frame field; BIT_LAST is the final data bit
  localparam logic [4:0] BIT_OP    = 5'd2;
  localparam logic [4:0] BIT_PHYAD = 5'd4;
  localparam logic [4:0] BIT_REGAD = 5'd9;
  localparam logic [4:0] BIT_TA    = 5'd14;
  localparam logic [4:0] BIT_DATA  = 5'd16;
  localparam logic [4:0] BIT_LAST  = 5'd31;

  // Register numbers of the permanent PHY identifier words
  localparam logic [4:0] REG_ID_HI = 5'd2;
  localparam logic [4:0] REG_ID_LO = 5'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_ADDR,
    S_TA,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } mdio_state_t;

  // True for the identifier registers, which no write path may change
  function automatic logic isReadOnly(input logic [4:0] addr);
    return (addr == REG_ID_HI) || (addr == REG_ID_LO);
  endfunction

endpackage

// File: rtl/mdio_regfile.sv
// mdio_regfile
// 32 x 16 PHY management register file with one synchronous write port and
// one asynchronous read port. Registers 2 and 3 hold the PHY identifier and
// always read back their fixed values; writes addressed to them are dropped.
//
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous active-high reset, clears every register
//   i_we      write enable
//   i_waddr   write address
//   i_wdata   write data
//   i_raddr   read address
//   o_rdata   read data (combinational)
module mdio_regfile
  import mdio_pkg::*;
#(
  parameter logic [15:0] PHY_ID_HI = 16'h0141,
  parameter logic [15:0] PHY_ID_LO = 16'h0CC2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [4:0]  i_raddr,
  output logic [15:0] o_rdata
);

  logic [15:0] r_mem [32];

  // Storage array. The identifier slots are never written, so their
  // contents stay at zero and are masked by the read mux below.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= 16'h0000;
      end
    end else if (i_we && !isReadOnly(i_waddr)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: identifier registers come from the parameters, so they read
  // correctly straight out of reset and can never be overwritten.
  always_comb begin
    o_rdata = r_mem[i_raddr];
    if (i_raddr == REG_ID_HI) begin
      o_rdata = PHY_ID_HI;
    end else if (i_raddr == REG_ID_LO) begin
      o_rdata = PHY_ID_LO;
    end
  end

endmodule

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder
// PHY-side Clause-22 MDIO responder. Follows MDC/MDIO from the station
// manager, decodes ST/OP/PHYAD/REGAD/TA/DATA, commits write frames into the
// local register file and shifts read data back toward the manager.
// Sampling happens on MDC rising edges, driving on MDC falling edges, both
// detected synchronously in the i_clk domain.
//
// Ports:
//   i_clk         system clock (MDC is synchronous to it)
//   i_rst         asynchronous active-high reset
//   i_mdc         management clock from the generator
//   i_mdio_out    generator-driven MDIO bit
//   i_mdio_oe     generator output enable (line reads 1 when low)
//   o_mdio_in     responder-driven MDIO bit, idles at 1
//   o_resp_oe     responder output enable, high for TA[1] and read data
//   i_host_we     local register write strobe
//   i_host_addr   local write address
//   i_host_wdata  local write data
//   o_wr_strobe   one-clock pulse when an MDIO write commits
//   o_wr_addr     register number of the last committed MDIO write
//   o_wr_data     data of the last committed MDIO write
//   o_frame_err   one-clock pulse on a bad ST or illegal OP
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR  = 5'h03,
  parameter logic [15:0] PHY_ID_HI = 16'h0141,
  parameter logic [15:0] PHY_ID_LO = 16'h0CC2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mdc,
  input  logic        i_mdio_out,
  input  logic        i_mdio_oe,
  output logic        o_mdio_in,
  output logic        o_resp_oe,
  input  logic        i_host_we,
  input  logic [4:0]  i_host_addr,
  input  logic [15:0] i_host_wdata,
  output logic        o_wr_strobe,
  output logic [4:0]  o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic        o_frame_err
);

  mdio_state_t r_state;
  mdio_state_t w_stateNext;

  logic        r_mdcQ;
  logic [4:0]  r_bitCnt;
  logic        r_opHi;
  logic        r_isRead;
  logic [8:0]  r_addrSh;
  logic [4:0]  r_regad;
  logic [14:0] r_wdata;
  logic [15:0] r_shift;
  logic        r_mdioIn;
  logic        r_respOe;
  logic        r_wrStrobe;
  logic [4:0]  r_wrAddr;
  logic [15:0] r_wrData;
  logic        r_frameErr;

  logic        w_line;
  logic        w_rise;
  logic        w_fall;
  logic [1:0]  w_opNow;
  logic [9:0]  w_addrFull;
  logic [15:0] w_commitData;
  logic [15:0] w_rdData;
  logic        w_rfWe;
  logic [4:0]  w_rfAddr;
  logic [15:0] w_rfData;

  logic        w_errPulse;
  logic        w_commit;
  logic        w_latch;
  logic        w_driveTa;
  logic        w_driveBit;
  logic        w_release;

  // The bus is pulled up whenever the generator is not driving it
  assign w_line = i_mdio_oe ? i_mdio_out : 1'b1;
  assign w_rise = i_mdc & ~r_mdcQ;
  assign w_fall = ~i_mdc & r_mdcQ;

  // The final bit of a field is still on the line during its rise, so the
  // complete field is formed from the shifted bits plus the live line value.
  assign w_opNow      = {r_opHi, w_line};
  assign w_addrFull   = {r_addrSh, w_line};
  assign w_commitData = {r_wdata, w_line};

  // A committing MDIO write takes the single write port; a host write on
  // that same clock is the one that gets dropped.
  assign w_rfWe   = w_commit | i_host_we;
  assign w_rfAddr = w_commit ? r_regad : i_host_addr;
  assign w_rfData = w_commit ? w_commitData : i_host_wdata;

  mdio_regfile #(
    .PHY_ID_HI (PHY_ID_HI),
    .PHY_ID_LO (PHY_ID_LO)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_rfWe),
    .i_waddr (w_rfAddr),
    .i_wdata (w_rfData),
    .i_raddr (w_addrFull[4:0]),
    .o_rdata (w_rdData)
  );

  // Frame state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode plus one-cycle control pulses for the datapath.
  // r_bitCnt holds the index of the bit the next rise will sample, so a
  // fall seen with r_bitCnt == k follows the sample of bit k-1. After bit
  // 31 the counter wraps to 0, which is how the read side spots the final
  // fall that releases the line.
  always_comb begin
    w_stateNext = r_state;
    w_errPulse  = 1'b0;
    w_commit    = 1'b0;
    w_latch     = 1'b0;
    w_driveTa   = 1'b0;
    w_driveBit  = 1'b0;
    w_release   = 1'b0;
    if (w_rise) begin
      case (r_state)
        S_IDLE: begin
          if (!w_line) begin
            w_stateNext = S_ST;
          end
        end
        S_ST: begin
          if (w_line) begin
            w_stateNext = S_OP;
          end else begin
            w_errPulse  = 1'b1;
            w_stateNext = S_IDLE;
          end
        end
        S_OP: begin
          if (r_bitCnt == BIT_OP + 5'd1) begin
            if (w_opNow == OP_WRITE || w_opNow == OP_READ) begin
              w_stateNext = S_ADDR;
            end else begin
              w_errPulse  = 1'b1;
              w_stateNext = S_IGNORE;
            end
          end
        end
        S_ADDR: begin
          if (r_bitCnt == BIT_TA - 5'd1) begin
            if (w_addrFull[9:5] == PHY_ADDR) begin
              w_stateNext = S_TA;
              w_latch     = r_isRead;
            end else begin
              w_stateNext = S_IGNORE;
            end
          end
        end
        S_TA: begin
          if (r_bitCnt == BIT_DATA - 5'd1) begin
            w_stateNext = r_isRead ? S_RDATA : S_WDATA;
          end
        end
        S_WDATA: begin
          if (r_bitCnt == BIT_LAST) begin
            w_commit    = !isReadOnly(r_regad);
            w_stateNext = S_IDLE;
          end
        end
        S_IGNORE: begin
          if (r_bitCnt == BIT_LAST) begin
            w_stateNext = S_IDLE;
          end
        end
        default: begin
          w_stateNext = r_state;
        end
      endcase
    end else if (w_fall) begin
      case (r_state)
        S_TA: begin
          if (r_isRead && r_bitCnt == BIT_TA + 5'd1) begin
            w_driveTa = 1'b1;
          end
        end
        S_RDATA: begin
          if (r_bitCnt == 5'd0) begin
            w_release   = 1'b1;
            w_stateNext = S_IDLE;
          end else begin
            w_driveBit = 1'b1;
          end
        end
        default: begin
          w_stateNext = r_state;
        end
      endcase
    end
  end

  // Datapath: MDC edge history, bit counter, field capture, read shifter,
  // line driver and the write-commit / error reporting registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mdcQ     <= 1'b0;
      r_bitCnt   <= 5'd0;
      r_opHi     <= 1'b0;
      r_isRead   <= 1'b0;
      r_addrSh   <= 9'd0;
      r_regad    <= 5'd0;
      r_wdata    <= 15'd0;
      r_shift    <= 16'h0000;
      r_mdioIn   <= 1'b1;
      r_respOe   <= 1'b0;
      r_wrStrobe <= 1'b0;
      r_wrAddr   <= 5'd0;
      r_wrData   <= 16'h0000;
      r_frameErr <= 1'b0;
    end else begin
      r_mdcQ     <= i_mdc;
      r_frameErr <= w_errPulse;
      r_wrStrobe <= w_commit;
      if (w_commit) begin
        r_wrAddr <= r_regad;
        r_wrData <= w_commitData;
      end
      if (w_rise) begin
        if (w_stateNext == S_IDLE) begin
          r_bitCnt <= 5'd0;
        end else if (r_state == S_IDLE) begin
          r_bitCnt <= 5'd1;
        end else begin
          r_bitCnt <= r_bitCnt + 5'd1;
        end
        if (r_state == S_OP && r_bitCnt == BIT_OP) begin
          r_opHi <= w_line;
        end
        if (r_state == S_OP && r_bitCnt == BIT_OP + 5'd1) begin
          r_isRead <= (w_opNow == OP_READ);
        end
        if (r_state == S_ADDR) begin
          r_addrSh <= {r_addrSh[7:0], w_line};
        end
        if (r_state == S_ADDR && r_bitCnt == BIT_TA - 5'd1) begin
          r_regad <= w_addrFull[4:0];
        end
        if (w_latch) begin
          r_shift <= w_rdData;
        end
        if (r_state == S_WDATA) begin
          r_wdata <= {r_wdata[13:0], w_line};
        end
      end
      if (w_driveTa) begin
        r_respOe <= 1'b1;
        r_mdioIn <= 1'b0;
      end
      if (w_driveBit) begin
        r_mdioIn <= r_shift[15];
        r_shift  <= {r_shift[14:0], 1'b0};
      end
      if (w_release) begin
        r_respOe <= 1'b0;
        r_mdioIn <= 1'b1;
      end
    end
  end

  assign o_mdio_in   = r_mdioIn;
  assign o_resp_oe   = r_respOe;
  assign o_wr_strobe = r_wrStrobe;
  assign o_wr_addr   = r_wrAddr;
  assign o_wr_data   = r_wrData;
  assign o_frame_err = r_frameErr;

endmodule
